flash_pcm_streamer: RTL and testbench

Streams packed signed PCM samples from the Avalon-MM flash port to the audio codec write interface. It generalises the fixed-rate, fixed-volume player to parametrised sample packing, a programmable address window, runtime speed and volume controls, pause, and loop/one-shot operation. A one-word prefetch buffer overlaps flash reads with codec writes. It sits between flash_inst and the codec instance in the top level.

---
 rtl/flash_pcm_streamer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_flash_pcm_streamer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_pcm_streamer.sv
// flash_pcm_streamer
//   Streams packed signed PCM samples from an Avalon-MM flash port to the
//   audio codec write interface. Supports a programmable word window,
//   loop/one-shot playback, pause, speed (normal/fast/slow) and volume
//   (arithmetic right shift) controls. A one-word prefetch buffer lets the
//   next flash read overlap the codec handshakes of the current word.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   start                      1-cycle pulse, latches base_addr/word_count
//   loop_en, pause             loop/one-shot select, hold before next sample
//   speed_sel, vol_shift       per-sample speed mode and volume shift
//   base_addr, word_count      playback window (in flash words)
//   busy, done                 status: playing, end-of-one-shot pulse
//   flash_mem_*                Avalon-MM read master
//   write_s, write_ready       codec write strobe / FIFO ready handshake
//   writedata_left/_right      sample to codec (both channels identical)
module flash_pcm_streamer #(
  parameter int ADDR_W           = 23,
  parameter int SAMPLE_W         = 16,
  parameter int SAMPLES_PER_WORD = 2,
  parameter int SHIFT_W          = 4,
  localparam int DATA_W          = SAMPLE_W * SAMPLES_PER_WORD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                loop_en,
  input  logic                pause,
  input  logic [1:0]          speed_sel,
  input  logic [SHIFT_W-1:0]  vol_shift,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   word_count,
  output logic                busy,
  output logic                done,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  input  logic                flash_mem_waitrequest,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic                write_s,
  input  logic                write_ready,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right
);

  // Index needs headroom for idx+2 so the fast-mode skip cannot overflow.
  localparam int IDX_W = $clog2(SAMPLES_PER_WORD + 2);
  localparam logic [IDX_W-1:0] SPW_L = IDX_W'(SAMPLES_PER_WORD);

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_WAIT = 2'd2;

  localparam logic [2:0] P_IDLE       = 3'd0;
  localparam logic [2:0] P_LOAD       = 3'd1;
  localparam logic [2:0] P_WAIT_READY = 3'd2;
  localparam logic [2:0] P_SEND       = 3'd3;
  localparam logic [2:0] P_WAIT_ACK   = 3'd4;
  localparam logic [2:0] P_NEXT       = 3'd5;

  logic [1:0]          f_state_q, f_state_d;
  logic [2:0]          p_state_q, p_state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   req_left_q, req_left_d;     // words still to request
  logic                inflight_last_q, inflight_last_d;
  logic                pf_valid_q, pf_valid_d;
  logic [DATA_W-1:0]   pf_data_q, pf_data_d;
  logic                pf_last_q, pf_last_d;       // word ends a one-shot
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic                cur_last_q, cur_last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rep_q, rep_d;               // slow mode: second send pending
  logic                write_s_q, write_s_d;
  logic [SAMPLE_W-1:0] wdata_q, wdata_d;

  logic signed [SAMPLE_W-1:0] sample;
  logic [IDX_W-1:0]           nxt;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    f_state_d       = f_state_q;
    p_state_d       = p_state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    base_d          = base_q;
    count_d         = count_q;
    addr_d          = addr_q;
    req_left_d      = req_left_q;
    inflight_last_d = inflight_last_q;
    pf_valid_d      = pf_valid_q;
    pf_data_d       = pf_data_q;
    pf_last_d       = pf_last_q;
    cur_d           = cur_q;
    cur_last_d      = cur_last_q;
    idx_d           = idx_q;
    rep_d           = rep_q;
    write_s_d       = write_s_q;
    wdata_d         = wdata_q;
    nxt             = '0;

    sample = '0;
    for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
      if (idx_q == IDX_W'(i)) sample = cur_q[i*SAMPLE_W +: SAMPLE_W];
    end

    if (start && !busy_q) begin
      base_d     = base_addr;
      count_d    = word_count;
      addr_d     = base_addr;
      req_left_d = word_count;
      if (word_count == '0) begin
        done_d = 1'b1;
      end else begin
        busy_d    = 1'b1;
        p_state_d = P_LOAD;
      end
    end

    // Fetch FSM: one outstanding read, only into an empty prefetch buffer.
    case (f_state_q)
      F_IDLE: begin
        if (busy_q && !pf_valid_q && (req_left_q != '0)) f_state_d = F_REQ;
      end
      F_REQ: begin
        if (!flash_mem_waitrequest) begin
          f_state_d = F_WAIT;
          if (req_left_q == ADDR_W'(1)) begin
            // loop_en is committed here, when the last word is requested.
            if (loop_en) begin
              addr_d          = base_q;
              req_left_d      = count_q;
              inflight_last_d = 1'b0;
            end else begin
              req_left_d      = '0;
              inflight_last_d = 1'b1;
            end
          end else begin
            addr_d          = addr_q + ADDR_W'(1);
            req_left_d      = req_left_q - ADDR_W'(1);
            inflight_last_d = 1'b0;
          end
        end
      end
      F_WAIT: begin
        if (flash_mem_readdatavalid) begin
          pf_valid_d = 1'b1;
          pf_data_d  = flash_mem_readdata;
          pf_last_d  = inflight_last_q;
          f_state_d  = F_IDLE;
        end
      end
      default: f_state_d = F_IDLE;
    endcase

    // Play FSM. P_LOAD only consumes a full buffer, and the fetch side only
    // fills an empty one, so the two never write pf_valid in the same cycle.
    case (p_state_q)
      P_IDLE: ;
      P_LOAD: begin
        if (pf_valid_q) begin
          cur_d      = pf_data_q;
          cur_last_d = pf_last_q;
          pf_valid_d = 1'b0;
          idx_d      = '0;
          rep_d      = 1'b0;
          p_state_d  = P_WAIT_READY;
        end
      end
      P_WAIT_READY: begin
        if (write_ready && !pause) p_state_d = P_SEND;
      end
      P_SEND: begin
        wdata_d   = sample >>> vol_shift;
        write_s_d = 1'b1;
        p_state_d = P_WAIT_ACK;
      end
      P_WAIT_ACK: begin
        if (!write_ready) begin
          write_s_d = 1'b0;
          p_state_d = P_NEXT;
        end
      end
      P_NEXT: begin
        if (speed_sel == 2'b10 && !rep_q) begin
          rep_d     = 1'b1;
          p_state_d = P_WAIT_READY;
        end else begin
          rep_d = 1'b0;
          nxt   = idx_q + IDX_W'(1);
          if (speed_sel == 2'b01 && nxt[0]) nxt = nxt + IDX_W'(1);
          if (nxt >= SPW_L) begin
            if (cur_last_q) begin
              done_d    = 1'b1;
              busy_d    = 1'b0;
              p_state_d = P_IDLE;
            end else begin
              p_state_d = P_LOAD;
            end
          end else begin
            idx_d     = nxt;
            p_state_d = P_WAIT_READY;
          end
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset as well, so writedata and the
      // address read back as zero after reset instead of stale values.
      f_state_q       <= F_IDLE;
      p_state_q       <= P_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      base_q          <= '0;
      count_q         <= '0;
      addr_q          <= '0;
      req_left_q      <= '0;
      inflight_last_q <= 1'b0;
      pf_valid_q      <= 1'b0;
      pf_data_q       <= '0;
      pf_last_q       <= 1'b0;
      cur_q           <= '0;
      cur_last_q      <= 1'b0;
      idx_q           <= '0;
      rep_q           <= 1'b0;
      write_s_q       <= 1'b0;
      wdata_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      f_state_q       <= f_state_d;
      p_state_q       <= p_state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      base_q          <= base_d;
      count_q         <= count_d;
      addr_q          <= addr_d;
      req_left_q      <= req_left_d;
      inflight_last_q <= inflight_last_d;
      pf_valid_q      <= pf_valid_d;
      pf_data_q       <= pf_data_d;
      pf_last_q       <= pf_last_d;
      cur_q           <= cur_d;
      cur_last_q      <= cur_last_d;
      idx_q           <= idx_d;
      rep_q           <= rep_d;
      write_s_q       <= write_s_d;
      wdata_q         <= wdata_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign flash_mem_read    = (f_state_q == F_REQ);
  assign flash_mem_address = addr_q;
  assign write_s           = write_s_q;
  assign writedata_left    = wdata_q;
  assign writedata_right   = wdata_q;

endmodule

// File: tb/tb_flash_pcm_streamer.sv
// Directed testbench for flash_pcm_streamer with a flash slave model
// (programmable waitrequest/latency) and a codec ready/ack model.
module tb_flash_pcm_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        loop_en = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  speed_sel = 2'b00;
  logic [3:0]  vol_shift = 4'd0;
  logic [22:0] base_addr = '0;
  logic [22:0] word_count = '0;
  logic        busy, done, flash_mem_read, write_s;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest = 1'b0;
  logic [31:0] flash_mem_readdata = '0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic        write_ready = 1'b1;
  logic [15:0] writedata_left, writedata_right;

  flash_pcm_streamer dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en), .pause(pause),
    .speed_sel(speed_sel), .vol_shift(vol_shift), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .write_s(write_s), .write_ready(write_ready),
    .writedata_left(writedata_left), .writedata_right(writedata_right)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Flash slave model
  logic [31:0] mem [0:63];
  logic [22:0] addrs [$];
  int          wr_cycles = 0;
  int          lat = 1;
  int          wait_ctr = 0;
  int          pend_cnt = 0;
  logic [22:0] pend_addr = '0;

  always @(negedge clk) begin
    flash_mem_readdatavalid = 1'b0;
    if (reset) begin
      pend_cnt = 0;
      wait_ctr = 0;
      flash_mem_waitrequest = 1'b0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata = mem[pend_addr[5:0]];
        end
      end
      if (flash_mem_read) begin
        if (wait_ctr < wr_cycles) begin
          flash_mem_waitrequest = 1'b1;
          wait_ctr++;
        end else begin
          flash_mem_waitrequest = 1'b0;
          wait_ctr  = 0;
          pend_cnt  = lat;
          pend_addr = flash_mem_address;
          addrs.push_back(flash_mem_address);
        end
      end else begin
        flash_mem_waitrequest = 1'b0;
        wait_ctr = 0;
      end
    end
  end

  // Codec model: accepts a strobe by dropping ready, re-raises once strobe drops.
  logic [15:0] got [$];
  int          lr_bad = 0;

  always @(negedge clk) begin
    if (reset) begin
      write_ready = 1'b1;
    end else if (write_s && write_ready) begin
      got.push_back(writedata_left);
      if (writedata_right !== writedata_left) lr_bad++;
      write_ready = 1'b0;
    end else if (!write_s && !write_ready) begin
      write_ready = 1'b1;
    end
  end

  int done_cnt = 0;
  int done_while_busy = 0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (busy) done_while_busy++;
    end
  end

  task automatic start_play(input logic [22:0] base, input logic [22:0] cnt,
                            input logic lp, input logic [1:0] spd, input logic [3:0] vs);
    got.delete();
    addrs.delete();
    base_addr = base; word_count = cnt; loop_en = lp; speed_sel = spd; vol_shift = vs;
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  logic [15:0] exp1 [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
  logic [15:0] exp2 [4] = '{16'hFE00, 16'h01FF, 16'hFFFF, 16'h0000};

  initial begin
    logic ok;
    int   d0, n0, a0;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h10] = 32'h7FFF8000;
    mem[6'h11] = 32'h0001FFFF;
    mem[6'h20] = 32'h00020001;
    mem[0] = 32'h00110010;
    mem[1] = 32'h00130012;
    mem[2] = 32'h00150014;
    for (int i = 0; i < 4; i++) mem[6'h30 + i] = {16'(16'h0100 + 2*i + 1), 16'(16'h0100 + 2*i)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_read", 32'(flash_mem_read), 32'h0);
    check("rst_write_s", 32'(write_s), 32'h0);
    check("rst_addr", 32'(flash_mem_address), 32'h0);
    check("rst_wdata", 32'(writedata_left), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Normal playback, two words
    d0 = done_cnt;
    start_play(23'h10, 23'd2, 1'b0, 2'b00, 4'd0);
    check("t1_busy_after_start", 32'(busy), 32'h1);
    wait_done(d0, 500, ok);
    check("t1_done_seen", 32'(ok), 32'h1);
    repeat (10) @(negedge clk);
    #1;
    check("t1_done_pulses", 32'(done_cnt - d0), 32'h1);
    check("t1_busy_end", 32'(busy), 32'h0);
    check("t1_nsamples", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_s%0d", i), 32'(got[i]), 32'(exp1[i]));
    check("t1_nreads", 32'(addrs.size()), 32'd2);
    check("t1_addr0", 32'(addrs[0]), 32'h10);
    check("t1_addr1", 32'(addrs[1]), 32'h11);

    // Volume shift 6
    d0 = done_cnt;
    start_play(23'h10, 23'd2, 1'b0, 2'b00, 4'd6);
    wait_done(d0, 500, ok);
    check("t2_done_seen", 32'(ok), 32'h1);
    check("t2_nsamples", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_s%0d", i), 32'(got[i]), 32'(exp2[i]));

    // Slow mode
    d0 = done_cnt;
    start_play(23'h20, 23'd1, 1'b0, 2'b10, 4'd0);
    wait_done(d0, 500, ok);
    check("t3_slow_done", 32'(ok), 32'h1);
    check("t3_slow_n", 32'(got.size()), 32'd4);
    check("t3_slow_s0", 32'(got[0]), 32'h1);
    check("t3_slow_s1", 32'(got[1]), 32'h1);
    check("t3_slow_s2", 32'(got[2]), 32'h2);
    check("t3_slow_s3", 32'(got[3]), 32'h2);

    // Fast mode
    d0 = done_cnt;
    start_play(23'h20, 23'd1, 1'b0, 2'b01, 4'd0);
    wait_done(d0, 500, ok);
    check("t3_fast_done", 32'(ok), 32'h1);
    check("t3_fast_n", 32'(got.size()), 32'd1);
    check("t3_fast_s0", 32'(got[0]), 32'h1);

    // word_count = 0: done on the cycle after start, no reads
    d0 = done_cnt;
    start_play(23'h10, 23'd0, 1'b0, 2'b00, 4'd0);
    check("t4_zero_done", 32'(done), 32'h1);
    check("t4_zero_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);
    #1;
    check("t4_zero_pulses", 32'(done_cnt - d0), 32'h1);
    check("t4_zero_reads", 32'(addrs.size()), 32'h0);

    // Pause mid-handshake
    wr_cycles = 0; lat = 2;
    d0 = done_cnt;
    start_play(23'h30, 23'd4, 1'b0, 2'b00, 4'd0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (write_s && got.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_ack_found", 32'(ok), 32'h1);
    pause = 1'b1;
    n0 = got.size();
    a0 = addrs.size();
    repeat (50) @(posedge clk);
    #1;
    check("t5_pause_one_completes", 32'(got.size()), 32'(n0 + 1));
    check("t5_pause_write_s", 32'(write_s), 32'h0);
    check("t5_pause_reads_le1", 32'(addrs.size() - a0 <= 1), 32'h1);
    pause = 1'b0;
    wait_done(d0, 500, ok);
    check("t5_done_seen", 32'(ok), 32'h1);
    check("t5_nsamples", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t5_s%0d", i), 32'(got[i]), 32'(16'h0100 + i));

    // Loop with slow slave
    wr_cycles = 4; lat = 3;
    d0 = done_cnt;
    start_play(23'h0, 23'd3, 1'b1, 2'b00, 4'd0);
    repeat (400) @(negedge clk);
    #1;
    check("t6_no_done", 32'(done_cnt - d0), 32'h0);
    check("t6_busy", 32'(busy), 32'h1);
    check("t6_nreads_ge7", 32'(addrs.size() >= 7), 32'h1);
    for (int i = 0; i < 7; i++) check($sformatf("t6_a%0d", i), 32'(addrs[i]), 32'(i % 3));
    check("t6_nsamples_ge12", 32'(got.size() >= 12), 32'h1);
    for (int i = 0; i < 12; i++) check($sformatf("t6_s%0d", i), 32'(got[i]), 32'(16'h10 + (i % 6)));

    // Reset while read=1 and waitrequest=1
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (flash_mem_read && flash_mem_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    check("t7_stall_found", 32'(ok), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t7_read", 32'(flash_mem_read), 32'h0);
    check("t7_write_s", 32'(write_s), 32'h0);
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_addr", 32'(flash_mem_address), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Restart after reset
    wr_cycles = 0; lat = 1;
    d0 = done_cnt;
    start_play(23'h10, 23'd2, 1'b0, 2'b00, 4'd0);
    wait_done(d0, 500, ok);
    check("t8_done_seen", 32'(ok), 32'h1);
    check("t8_nsamples", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t8_s%0d", i), 32'(got[i]), 32'(exp1[i]));

    check("left_eq_right", 32'(lr_bad), 32'h0);
    check("done_never_with_busy", 32'(done_while_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
